// File: rtl/div3_share_ctrl.sv
// div3_share_ctrl: round-robin arbiter sharing one
// divide_by_three unit, with timeout watchdog.
module div3_share_ctrl #(
  parameter int  NUM_REQ   = 4,
  parameter int  DATAWIDTH = 16,
  parameter int  TIMEOUT   = 64,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_vld,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_rdy,
  output logic                         div_vld_in,
  output logic [DATAWIDTH-1:0]         div_data_in,
  input  logic                         div_vld_out,
  input  logic [DATAWIDTH-1:0]         div_quotient,
  input  logic [1:0]                   div_reminder,
  output logic                         rsp_vld,
  input  logic                         rsp_rdy,
  output logic [ID_W-1:0]              rsp_id,
  output logic [DATAWIDTH-1:0]         rsp_quotient,
  output logic [1:0]                   rsp_reminder,
  output logic                         rsp_err,
  output logic                         busy
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [ID_W-1:0]        last_grant;
  logic [ID_W-1:0]        id_q;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grant_id;
  logic [ID_W-1:0]        pos;
  logic                   found;
  logic                   accept;
  logic                   hit;
  logic                   expire;
  logic                   rsp_fire;
  logic [DATAWIDTH-1:0]   req_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_arr[g] = req_data[g*DATAWIDTH +: DATAWIDTH];
  end

  // First valid requester after last_grant, with wrap
  always_comb begin
    grant    = '0;
    grant_id = '0;
    pos      = '0;
    found    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_vld[pos]) begin
        found       = 1'b1;
        grant_id    = pos;
        grant[pos]  = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (found) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT:  if (hit || expire) state_nx = RESP;
      RESP:  if (rsp_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Per-state strobes; req_rdy is the only comb output
  always_comb begin
    req_rdy  = '0;
    accept   = 1'b0;
    hit      = 1'b0;
    expire   = 1'b0;
    rsp_fire = 1'b0;
    unique case (state)
      IDLE: begin
        req_rdy = rst_n ? grant : '0;
        accept  = found;
      end
      WAIT: begin
        hit    = div_vld_out;
        expire = (cnt == TO_LAST);
      end
      RESP: rsp_fire = rsp_rdy;
      default: ;
    endcase
  end

  // Datapath and registered outputs; result beats timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant   <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      cnt          <= '0;
      div_vld_in   <= 1'b0;
      div_data_in  <= '0;
      rsp_vld      <= 1'b0;
      rsp_id       <= '0;
      rsp_quotient <= '0;
      rsp_reminder <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      div_vld_in <= accept;
      if (accept) begin
        div_data_in <= req_arr[grant_id];
        id_q        <= grant_id;
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CNT_W'(1);
      if (hit) begin
        rsp_id       <= id_q;
        rsp_quotient <= div_quotient;
        rsp_reminder <= div_reminder;
        rsp_err      <= 1'b0;
      end else if (expire) begin
        rsp_id       <= id_q;
        rsp_quotient <= '0;
        rsp_reminder <= '0;
        rsp_err      <= 1'b1;
      end
      rsp_vld <= (state_nx == RESP);
      busy    <= (state_nx != IDLE);
      if (rsp_fire) last_grant <= id_q;
    end
  end

endmodule

// File: tb/tb_div3_share_ctrl.sv
// tb_div3_share_ctrl: scenario tasks plus randomized
// traffic against an arithmetic round-robin model.
module tb_div3_share_ctrl;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_vld;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_rdy;
  logic            div_vld_in;
  logic [DW-1:0]   div_data_in;
  logic            div_vld_out;
  logic [DW-1:0]   div_quotient;
  logic [1:0]      div_reminder;
  logic            rsp_vld;
  logic            rsp_rdy;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_quotient;
  logic [1:0]      rsp_reminder;
  logic            rsp_err;
  logic            busy;
  logic [DW-1:0]   ops [N];

  assign req_data = {ops[3], ops[2], ops[1], ops[0]};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;
  int ref_last = N - 1;

  int            div_lat = 3;
  int            cd = 0;
  int            issue_cnt = 0;
  logic [DW-1:0] op_seen;

  div3_share_ctrl #(
    .NUM_REQ(N), .DATAWIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_data(req_data),
    .req_rdy(req_rdy),
    .div_vld_in(div_vld_in), .div_data_in(div_data_in),
    .div_vld_out(div_vld_out),
    .div_quotient(div_quotient),
    .div_reminder(div_reminder),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_id(rsp_id), .rsp_quotient(rsp_quotient),
    .rsp_reminder(rsp_reminder), .rsp_err(rsp_err),
    .busy(busy)
  );

  // Divider model: result div_lat cycles after the issue cycle
  initial begin
    div_vld_out  = 1'b0;
    div_quotient = '0;
    div_reminder = '0;
    op_seen      = '0;
    forever begin
      @(posedge clk); #1;
      div_vld_out = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          div_vld_out  = 1'b1;
          div_quotient = 16'(op_seen / 3);
          div_reminder = 2'(op_seen % 3);
        end
      end
      if (div_vld_in === 1'b1) begin
        issue_cnt++;
        op_seen = div_data_in;
        cd      = div_lat;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog sim time expired");
    $fatal(1);
  end

  function automatic int rr_pick(int last, logic [3:0] m);
    logic [1:0] j;
    for (int k = 1; k <= N; k++) begin
      j = 2'((last + k) % N);
      if (m[j]) return int'(j);
    end
    return -1;
  endfunction

  function automatic int oh2id(logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    ref_last = N - 1;
  endtask

  task automatic wait_accept(
    output bit ok, output int id, output int t);
    ok = 1'b0; id = -1; t = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (|(req_rdy & req_vld)) begin
        ok = 1'b1;
        t  = cyc;
        id = oh2id(req_rdy);
      end
    end
  endtask

  task automatic wait_rsp(output bit ok, output int t);
    ok = 1'b0; t = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (rsp_vld === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_vld = 4'hF;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (req_rdy !== 4'b0)
      $display("FAIL rst_req_rdy got %b want 0", req_rdy);
    else passed++;
    checks++;
    if (div_vld_in !== 1'b0)
      $display("FAIL rst_div_vld_in got %b want 0", div_vld_in);
    else passed++;
    checks++;
    if (div_data_in !== 16'd0)
      $display("FAIL rst_div_data got %0d want 0", div_data_in);
    else passed++;
    checks++;
    if (rsp_vld !== 1'b0)
      $display("FAIL rst_rsp_vld got %b want 0", rsp_vld);
    else passed++;
    checks++;
    if ({rsp_id, rsp_quotient, rsp_reminder, rsp_err} !== 21'd0)
      $display("FAIL rst_rsp_fields got %0d/%0d/%0d/%0b want 0",
        rsp_id, rsp_quotient, rsp_reminder, rsp_err);
    else passed++;
    checks++;
    if (busy !== 1'b0)
      $display("FAIL rst_busy got %b want 0", busy);
    else passed++;
    tick();
    req_vld = '0;
    rst_n = 1'b1;
    ref_last = N - 1;
  endtask

  task automatic test_single();
    bit ok; int id, t, tr, n0, exp;
    div_lat = 3; rsp_rdy = 1'b1;
    ops[2] = 16'd100; req_vld = 4'b0100;
    exp = rr_pick(ref_last, req_vld);
    n0 = issue_cnt;
    wait_accept(ok, id, t);
    checks++;
    if (id !== exp)
      $display("FAIL single_grant got %0d want %0d", id, exp);
    else passed++;
    tick();
    req_vld = '0;
    wait_rsp(ok, tr);
    checks++;
    if (!ok || tr - t !== 5)
      $display("FAIL single_latency got %0d want 5", tr - t);
    else passed++;
    checks++;
    if (int'(rsp_id) !== exp)
      $display("FAIL single_id got %0d want %0d", rsp_id, exp);
    else passed++;
    checks++;
    if (rsp_quotient !== 16'(100 / 3) || rsp_reminder !== 2'(100 % 3))
      $display("FAIL single_result got %0d/%0d want 33/1",
        rsp_quotient, rsp_reminder);
    else passed++;
    checks++;
    if (rsp_err !== 1'b0)
      $display("FAIL single_err got %b want 0", rsp_err);
    else passed++;
    checks++;
    if (issue_cnt - n0 !== 1)
      $display("FAIL single_issue_cycles got %0d want 1", issue_cnt - n0);
    else passed++;
    ref_last = exp;
    tick();
  endtask

  task automatic test_round_robin();
    bit ok; int id, t, tr, exp, prev_t;
    logic [DW-1:0] eop;
    do_reset();
    ops[0] = 16'd9;  ops[1] = 16'd10;
    ops[2] = 16'd11; ops[3] = 16'd12;
    div_lat = 3; rsp_rdy = 1'b1; req_vld = 4'hF;
    prev_t = 0;
    for (int k = 0; k < 5; k++) begin
      exp = rr_pick(ref_last, req_vld);
      eop = ops[2'(exp)];
      wait_accept(ok, id, t);
      checks++;
      if (id !== exp)
        $display("FAIL rr_grant[%0d] got %0d want %0d", k, id, exp);
      else passed++;
      if (k > 0) begin
        checks++;
        if (t - prev_t !== 6)
          $display("FAIL rr_period[%0d] got %0d want 6", k, t - prev_t);
        else passed++;
      end
      prev_t = t;
      wait_rsp(ok, tr);
      checks++;
      if (!ok || int'(rsp_id) !== exp ||
          rsp_quotient !== 16'(eop / 3) ||
          rsp_reminder !== 2'(eop % 3))
        $display("FAIL rr_rsp[%0d] got %0d:%0d/%0d want %0d:%0d/%0d",
          k, rsp_id, rsp_quotient, rsp_reminder,
          exp, eop / 3, eop % 3);
      else passed++;
      ref_last = exp;
    end
    tick();
    req_vld = '0;
  endtask

  task automatic test_backpressure();
    bit ok; int id, t, tr, exp, n0, tp;
    logic [1:0] sid; logic [DW-1:0] sq;
    logic [1:0] sr; logic se;
    ops[0] = 16'd20; ops[1] = 16'd21;
    ops[2] = 16'd22; ops[3] = 16'd23;
    div_lat = 2; rsp_rdy = 1'b0; req_vld = 4'hF;
    exp = rr_pick(ref_last, req_vld);
    wait_accept(ok, id, t);
    checks++;
    if (id !== exp)
      $display("FAIL bp_grant got %0d want %0d", id, exp);
    else passed++;
    wait_rsp(ok, tr);
    checks++;
    if (!ok || int'(rsp_id) !== exp ||
        rsp_quotient !== 16'(ops[2'(exp)] / 3))
      $display("FAIL bp_rsp got %0d:%0d want %0d:%0d",
        rsp_id, rsp_quotient, exp, ops[2'(exp)] / 3);
    else passed++;
    sid = rsp_id; sq = rsp_quotient;
    sr = rsp_reminder; se = rsp_err;
    n0 = issue_cnt;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_vld !== 1'b1 ||
          {rsp_id, rsp_quotient, rsp_reminder, rsp_err} !==
          {sid, sq, sr, se})
        $display("FAIL bp_hold[%0d] got %b:%0d:%0d want 1:%0d:%0d",
          k, rsp_vld, rsp_id, rsp_quotient, sid, sq);
      else passed++;
      checks++;
      if (req_rdy !== 4'b0)
        $display("FAIL bp_req_rdy[%0d] got %b want 0", k, req_rdy);
      else passed++;
      checks++;
      if (issue_cnt !== n0)
        $display("FAIL bp_issue[%0d] got %0d want %0d",
          k, issue_cnt, n0);
      else passed++;
    end
    tick();
    rsp_rdy = 1'b1;
    tp = cyc;
    ref_last = exp;
    exp = rr_pick(ref_last, req_vld);
    wait_accept(ok, id, t);
    checks++;
    if (id !== exp || t !== tp + 1)
      $display("FAIL bp_next got id %0d at +%0d want %0d at +1",
        id, t - tp, exp);
    else passed++;
    tick();
    req_vld = '0;
    wait_rsp(ok, tr);
    checks++;
    if (!ok || int'(rsp_id) !== exp)
      $display("FAIL bp_next_rsp got %0d want %0d", rsp_id, exp);
    else passed++;
    ref_last = exp;
    tick();
  endtask

  task automatic test_timeout();
    bit ok; int id, t, tr, exp;
    div_lat = 10; rsp_rdy = 1'b1;
    ops[1] = 16'd50; req_vld = 4'b0010;
    exp = rr_pick(ref_last, req_vld);
    wait_accept(ok, id, t);
    tick();
    req_vld = '0;
    wait_rsp(ok, tr);
    checks++;
    if (!ok || tr - t !== TO + 1)
      $display("FAIL to_latency got %0d want %0d", tr - t, TO + 1);
    else passed++;
    checks++;
    if (rsp_err !== 1'b1 || rsp_quotient !== 16'd0 ||
        rsp_reminder !== 2'd0 || int'(rsp_id) !== exp)
      $display("FAIL to_rsp got e%b %0d/%0d id%0d want e1 0/0 id%0d",
        rsp_err, rsp_quotient, rsp_reminder, rsp_id, exp);
    else passed++;
    ref_last = exp;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_vld !== 1'b0 || busy !== 1'b0)
        $display("FAIL to_late[%0d] got vld %b busy %b want 0 0",
          k, rsp_vld, busy);
      else passed++;
    end
    tick();
    div_lat = 3;
    ops[3] = 16'd200; req_vld = 4'b1000;
    exp = rr_pick(ref_last, req_vld);
    wait_accept(ok, id, t);
    tick();
    req_vld = '0;
    wait_rsp(ok, tr);
    checks++;
    if (!ok || tr - t !== 5 || rsp_err !== 1'b0 ||
        rsp_quotient !== 16'(200 / 3) ||
        rsp_reminder !== 2'(200 % 3) || int'(rsp_id) !== exp)
      $display("FAIL to_next got lat%0d e%b %0d/%0d want 5 e0 66/2",
        tr - t, rsp_err, rsp_quotient, rsp_reminder);
    else passed++;
    ref_last = exp;
    tick();
  endtask

  task automatic test_simultaneous();
    bit ok; int id, t, tr, exp;
    div_lat = TO - 1; rsp_rdy = 1'b1;
    ops[0] = 16'd17; req_vld = 4'b0001;
    exp = rr_pick(ref_last, req_vld);
    wait_accept(ok, id, t);
    tick();
    req_vld = '0;
    wait_rsp(ok, tr);
    checks++;
    if (!ok || tr - t !== TO + 1)
      $display("FAIL sim_latency got %0d want %0d", tr - t, TO + 1);
    else passed++;
    checks++;
    if (rsp_err !== 1'b0 || rsp_quotient !== 16'd5 ||
        rsp_reminder !== 2'd2 || int'(rsp_id) !== exp)
      $display("FAIL sim_rsp got e%b %0d/%0d want e0 5/2",
        rsp_err, rsp_quotient, rsp_reminder);
    else passed++;
    ref_last = exp;
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok; int id, t, tr, exp;
    div_lat = 5; rsp_rdy = 1'b1;
    ops[2] = 16'd77; req_vld = 4'b0100;
    wait_accept(ok, id, t);
    tick();
    req_vld = '0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ref_last = N - 1;
    @(negedge clk);
    checks++;
    if ({div_vld_in, div_data_in, rsp_vld, busy} !== 19'd0)
      $display("FAIL mid_rst_ctl got %b/%0d/%b/%b want 0",
        div_vld_in, div_data_in, rsp_vld, busy);
    else passed++;
    checks++;
    if ({rsp_id, rsp_quotient, rsp_reminder, rsp_err} !== 21'd0)
      $display("FAIL mid_rst_rsp got %0d/%0d/%0d/%b want 0",
        rsp_id, rsp_quotient, rsp_reminder, rsp_err);
    else passed++;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_vld !== 1'b0 || busy !== 1'b0)
        $display("FAIL mid_quiet[%0d] got vld %b busy %b want 0 0",
          k, rsp_vld, busy);
      else passed++;
    end
    tick();
    div_lat = 2;
    ops[0] = 16'd30; ops[2] = 16'd31;
    req_vld = 4'b0101;
    exp = rr_pick(ref_last, req_vld);
    wait_accept(ok, id, t);
    checks++;
    if (id !== exp)
      $display("FAIL mid_next_grant got %0d want %0d", id, exp);
    else passed++;
    tick();
    req_vld = '0;
    wait_rsp(ok, tr);
    checks++;
    if (!ok || rsp_quotient !== 16'd10 || rsp_err !== 1'b0)
      $display("FAIL mid_next_rsp got %0d e%b want 10 e0",
        rsp_quotient, rsp_err);
    else passed++;
    ref_last = exp;
    tick();
  endtask

  task automatic test_random();
    bit ok; int id, t, tr, exp, lat, stall, exp_lat;
    logic [3:0] pending;
    logic [1:0] j;
    logic [DW-1:0] eop, eq;
    logic [1:0] er;
    logic ee;
    bit abort;
    pending = '0;
    abort = 1'b0;
    for (int k = 0; k < 30 && !abort; k++) begin
      for (int i = 0; i < N; i++) begin
        j = 2'(i);
        if (!pending[j] && $urandom_range(0, 1) == 1) begin
          pending[j] = 1'b1;
          ops[j] = 16'($urandom_range(0, 65535));
        end
      end
      if (pending == 4'b0) begin
        j = 2'($urandom_range(0, 3));
        pending[j] = 1'b1;
        ops[j] = 16'($urandom_range(0, 65535));
      end
      lat = $urandom_range(1, 9);
      div_lat = lat;
      rsp_rdy = 1'b0;
      req_vld = pending;
      exp = rr_pick(ref_last, pending);
      eop = ops[2'(exp)];
      ee  = (lat > TO - 1);
      eq  = ee ? 16'd0 : 16'(eop / 3);
      er  = ee ? 2'd0 : 2'(eop % 3);
      exp_lat = ee ? TO + 1 : lat + 2;
      wait_accept(ok, id, t);
      checks++;
      if (!ok || id !== exp)
        $display("FAIL rnd_grant[%0d] got %0d want %0d", k, id, exp);
      else passed++;
      if (!ok || id < 0) begin
        abort = 1'b1;
      end else begin
        tick();
        pending[2'(id)] = 1'b0;
        req_vld = pending;
        wait_rsp(ok, tr);
        checks++;
        if (!ok || tr - t !== exp_lat)
          $display("FAIL rnd_latency[%0d] got %0d want %0d",
            k, tr - t, exp_lat);
        else passed++;
        checks++;
        if (int'(rsp_id) !== exp || rsp_quotient !== eq ||
            rsp_reminder !== er || rsp_err !== ee)
          $display("FAIL rnd_rsp[%0d] got %0d:%0d/%0d e%b want %0d:%0d/%0d e%b",
            k, rsp_id, rsp_quotient, rsp_reminder, rsp_err,
            exp, eq, er, ee);
        else passed++;
        stall = $urandom_range(0, 3);
        repeat (stall) tick();
        tick();
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        ref_last = exp;
      end
    end
    req_vld = '0;
  endtask

  initial begin
    rst_n   = 1'b0;
    req_vld = '0;
    rsp_rdy = 1'b0;
    for (int i = 0; i < N; i++) ops[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
